// File: rtl/flash_boot_loader.sv
// flash_boot_loader
//   Boot-time copy engine between the instruction flash ROM and instruction
//   memory. Walks ROM addresses 0..BOOT_WORDS-1, streams each word over a
//   valid/ready write port, holds the core until the image is copied and
//   reports a truncated additive checksum of every accepted word.
//
// Ports
//   clk            system clock
//   clk_en         global clock enable; all state holds while low
//   sync_rst       synchronous active-high reset (wins over clk_en)
//   RomAddress     combinational ROM word address (low bits of the pointer)
//   RomValue       ROM data for RomAddress, same cycle
//   MemWrite_Valid registered write request to instruction memory
//   MemWrite_Ready instruction memory accepts the write
//   MemWrite_Addr  registered write word address
//   MemWrite_Data  registered write data
//   Reboot_Req     restart the copy; honoured only once the copy is done
//   CoreHold       1 while the core must stay in reset
//   BootDone       1 once the image has been copied (level)
//   BootChecksum   sum mod 2**DATA_W of all accepted words
module flash_boot_loader #(
  parameter int ROM_ADDR_W = 10,
  parameter int DATA_W     = 16,
  parameter int BOOT_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  clk_en,
  input  logic                  sync_rst,
  output logic [ROM_ADDR_W-1:0] RomAddress,
  input  logic [DATA_W-1:0]     RomValue,
  output logic                  MemWrite_Valid,
  input  logic                  MemWrite_Ready,
  output logic [ROM_ADDR_W-1:0] MemWrite_Addr,
  output logic [DATA_W-1:0]     MemWrite_Data,
  input  logic                  Reboot_Req,
  output logic                  CoreHold,
  output logic                  BootDone,
  output logic [DATA_W-1:0]     BootChecksum
);

  typedef enum logic {
    ST_COPY = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  // Pointer is one bit wider than the address so BOOT_WORDS == 2**ROM_ADDR_W
  // is representable as the terminal count.
  localparam logic [ROM_ADDR_W:0] BootWordsC = (ROM_ADDR_W+1)'(BOOT_WORDS);
  localparam logic [ROM_ADDR_W:0] PtrOneC    = (ROM_ADDR_W+1)'(1);

  state_t                state_q,     state_d;
  logic [ROM_ADDR_W:0]   ptr_q,       ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [ROM_ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [DATA_W-1:0]     out_data_q,  out_data_d;
  logic [DATA_W-1:0]     checksum_q,  checksum_d;

  logic accept;
  logic load;

  assign accept = clk_en & out_valid_q & MemWrite_Ready;
  // A new word may enter the output register when it is empty or being
  // drained this very cycle, giving one word per cycle with Ready high.
  assign load   = clk_en & (state_q == ST_COPY) & (ptr_q < BootWordsC) &
                  (~out_valid_q | MemWrite_Ready);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    checksum_d  = checksum_q;

    if (load) begin
      out_data_d  = RomValue;
      out_addr_d  = ptr_q[ROM_ADDR_W-1:0];
      out_valid_d = 1'b1;
      ptr_d       = ptr_q + PtrOneC;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      checksum_d = checksum_q + out_data_q;
    end

    if (clk_en) begin
      unique case (state_q)
        ST_COPY: begin
          // All words fetched and the last one drained (or draining now).
          if ((ptr_q == BootWordsC) && (!out_valid_q || accept)) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (Reboot_Req) begin
            state_d    = ST_COPY;
            ptr_d      = '0;
            checksum_d = '0;
          end
        end
        default: state_d = ST_COPY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q     <= ST_COPY;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      checksum_q  <= checksum_d;
    end
  end

  assign RomAddress     = ptr_q[ROM_ADDR_W-1:0];
  assign MemWrite_Valid = out_valid_q;
  assign MemWrite_Addr  = out_addr_q;
  assign MemWrite_Data  = out_data_q;
  assign CoreHold       = (state_q == ST_COPY);
  assign BootDone       = (state_q == ST_DONE);
  assign BootChecksum   = checksum_q;

endmodule

// File: tb/tb_flash_boot_loader.sv
// tb_flash_boot_loader
//   Directed bench: a 4-word instance exercises handshake, clock enable,
//   reboot and reset behaviour; a full 1024-word instance runs alongside to
//   cover the terminal count and address wrap.
module tb_flash_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- small instance (BOOT_WORDS=4) ----------------
  logic        rst, en, rdy, reboot;
  logic [9:0]  s_rom_addr;
  logic [15:0] s_rom_val;
  logic        s_valid;
  logic [9:0]  s_addr;
  logic [15:0] s_data;
  logic        s_hold, s_done;
  logic [15:0] s_sum;
  logic [15:0] rom [0:3];

  assign s_rom_val = rom[s_rom_addr[1:0]];

  flash_boot_loader #(.ROM_ADDR_W(10), .DATA_W(16), .BOOT_WORDS(4)) dut (
    .clk(clk), .clk_en(en), .sync_rst(rst),
    .RomAddress(s_rom_addr), .RomValue(s_rom_val),
    .MemWrite_Valid(s_valid), .MemWrite_Ready(rdy),
    .MemWrite_Addr(s_addr), .MemWrite_Data(s_data),
    .Reboot_Req(reboot), .CoreHold(s_hold), .BootDone(s_done),
    .BootChecksum(s_sum)
  );

  // ---------------- big instance (BOOT_WORDS=1024) ----------------
  logic        b_rst;
  logic [9:0]  b_rom_addr;
  logic [15:0] b_rom_val;
  logic        b_valid;
  logic [9:0]  b_addr;
  logic [15:0] b_data;
  logic        b_hold, b_done;
  logic [15:0] b_sum;

  assign b_rom_val = {6'b0, b_rom_addr};

  flash_boot_loader #(.ROM_ADDR_W(10), .DATA_W(16), .BOOT_WORDS(1024)) dut_big (
    .clk(clk), .clk_en(1'b1), .sync_rst(b_rst),
    .RomAddress(b_rom_addr), .RomValue(b_rom_val),
    .MemWrite_Valid(b_valid), .MemWrite_Ready(1'b1),
    .MemWrite_Addr(b_addr), .MemWrite_Data(b_data),
    .Reboot_Req(1'b0), .CoreHold(b_hold), .BootDone(b_done),
    .BootChecksum(b_sum)
  );

  // ---------------- monitors (sample on falling edge) ----------------
  logic [9:0]  wr_addr [$];
  logic [15:0] wr_data [$];
  int unsigned wr_cyc  [$];
  int unsigned stall_viol = 0;
  logic        stall_prev = 1'b0;
  logic [9:0]  stall_addr;
  logic [15:0] stall_data;

  int unsigned b_cnt = 0;
  int unsigned b_order_err = 0;
  logic [15:0] b_acc = '0;
  logic [9:0]  b_last = '0;

  always @(negedge clk) begin
    if (stall_prev && !(s_valid && s_addr == stall_addr && s_data == stall_data))
      stall_viol++;
    stall_prev = s_valid & ~(rdy & en) & ~rst;
    stall_addr = s_addr;
    stall_data = s_data;
    if (en && s_valid && rdy && !rst) begin
      wr_addr.push_back(s_addr);
      wr_data.push_back(s_data);
      wr_cyc.push_back(cyc);
    end
    if (b_valid && !b_rst) begin
      if (b_addr != b_cnt[9:0]) b_order_err++;
      b_cnt++;
      b_acc = b_acc + b_data;
      b_last = b_addr;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic run_to_done(input int unsigned max, output int unsigned n);
    n = 0;
    while (s_hold && n < max) begin
      step();
      n++;
    end
  endtask

  task automatic check_writes(input string tag, input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [15:0] d3);
    logic [15:0] exp_d [0:3];
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
    check({tag, "_count"}, wr_addr.size(), 4);
    for (int k = 0; k < 4 && k < wr_addr.size(); k++) begin
      check($sformatf("%s_addr%0d", tag, k), wr_addr[k], k);
      check($sformatf("%s_data%0d", tag, k), wr_data[k], exp_d[k]);
    end
  endtask

  // ---------------- stimulus ----------------
  int unsigned n, start, p;
  logic [3:0] pat;

  initial begin
    rom[0] = 16'hD188; rom[1] = 16'hC220; rom[2] = 16'hC300; rom[3] = 16'hE380;
    rst = 1'b1; b_rst = 1'b1; en = 1'b1; rdy = 1'b1; reboot = 1'b0;
    step(); step();

    // Reset state
    check("rst_valid", s_valid, 0);
    check("rst_hold",  s_hold,  1);
    check("rst_done",  s_done,  0);
    check("rst_sum",   s_sum,   0);

    // T1: plain copy with Ready tied high
    clear_log();
    rst = 1'b0; b_rst = 1'b0;
    start = cyc;
    run_to_done(50, n);
    check("t1_done_cycles", n, 5);
    check("t1_hold", s_hold, 0);
    check("t1_done", s_done, 1);
    check("t1_sum",  s_sum,  16'h3A28);
    check_writes("t1", 16'hD188, 16'hC220, 16'hC300, 16'hE380);
    for (int k = 0; k < 4 && k < wr_cyc.size(); k++)
      check($sformatf("t1_lat%0d", k), wr_cyc[k] - start, k + 1);

    // T2: Ready toggling 1,0,0,1
    rst = 1'b1; step(); rst = 1'b0;
    clear_log();
    pat = 4'b1001; p = 0; n = 0;
    while (s_hold && n < 200) begin
      rdy = pat[p % 4];
      step();
      p++; n++;
    end
    rdy = 1'b1;
    check("t2_hold", s_hold, 0);
    check("t2_sum",  s_sum,  16'h3A28);
    check("t2_stall_stable", stall_viol, 0);
    check_writes("t2", 16'hD188, 16'hC220, 16'hC300, 16'hE380);

    // T3: clk_en low for 3 cycles mid-copy
    rst = 1'b1; step(); rst = 1'b0;
    clear_log();
    step(); step();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("t3_romaddr%0d", k), s_rom_addr, 2);
      check($sformatf("t3_valid%0d", k), s_valid, 1);
      check($sformatf("t3_addr%0d", k), s_addr, 1);
      check($sformatf("t3_data%0d", k), s_data, 16'hC220);
    end
    en = 1'b1;
    run_to_done(50, n);
    check("t3_hold", s_hold, 0);
    check("t3_sum",  s_sum,  16'h3A28);
    check_writes("t3", 16'hD188, 16'hC220, 16'hC300, 16'hE380);

    // T4: reboot from DONE with new ROM contents; a reboot pulse while
    // copying must be ignored
    for (int k = 0; k < 4; k++) rom[k] = 16'h0001;
    clear_log();
    reboot = 1'b1; step(); reboot = 1'b0;
    check("t4_hold_next", s_hold, 1);
    check("t4_done_next", s_done, 0);
    check("t4_sum_clr",   s_sum,  0);
    step();
    reboot = 1'b1; step(); reboot = 1'b0;
    run_to_done(50, n);
    check("t4_hold", s_hold, 0);
    check("t4_done", s_done, 1);
    check("t4_sum",  s_sum,  16'h0004);
    check_writes("t4", 16'h0001, 16'h0001, 16'h0001, 16'h0001);

    // T5: sync_rst after two accepted words
    rom[0] = 16'hD188; rom[1] = 16'hC220; rom[2] = 16'hC300; rom[3] = 16'hE380;
    rst = 1'b1; step(); rst = 1'b0;
    clear_log();
    n = 0;
    while (wr_addr.size() < 2 && n < 50) begin
      step();
      n++;
    end
    check("t5_two_accepted", wr_addr.size(), 2);
    rst = 1'b1; step();
    check("t5_valid_after_rst", s_valid, 0);
    check("t5_hold_after_rst",  s_hold,  1);
    check("t5_sum_after_rst",   s_sum,   0);
    clear_log();
    rst = 1'b0;
    run_to_done(50, n);
    check("t5_hold", s_hold, 0);
    check("t5_sum",  s_sum,  16'h3A28);
    check_writes("t5", 16'hD188, 16'hC220, 16'hC300, 16'hE380);

    // T6: full 1024-word image on the big instance
    n = 0;
    while (b_hold && n < 2000) begin
      step();
      n++;
    end
    repeat (5) step();
    check("t6_hold",     b_hold, 0);
    check("t6_done",     b_done, 1);
    check("t6_count",    b_cnt,  1024);
    check("t6_order",    b_order_err, 0);
    check("t6_last",     b_last, 10'h3FF);
    check("t6_rom_wrap", b_rom_addr, 0);
    check("t6_sum",      b_sum,  16'hFE00);
    check("t6_mon_sum",  b_acc,  16'hFE00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
